// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: iteration controller for an LDPC decoder.
// Launches decoder iterations, computes the syndrome of each hard-decision
// codeword P columns of H_t per cycle, and stops on a zero syndrome or
// after MAX_ITER iterations.
// Build option: define LDPC_EARLY_TERM_EN to stop as soon as the syndrome is
// zero; without it every decode runs exactly MAX_ITER iterations.
`timescale 1ns/1ps

module ldpc_iter_ctrl #(
   parameter int N        = 204,
   parameter int K        = 102,
   parameter int P        = 6,
   parameter int MAX_ITER = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N*(N-K)-1:0] H_t,
   output logic               dec_start,
   input  logic               dec_done,
   input  logic [N-1:0]       cw,
   output logic               busy,
   output logic               done,
   output logic               success,
   output logic [7:0]         iter_cnt,
   output logic [N-K-1:0]     syndrome
);

   localparam int M       = N - K;
   localparam int NCHUNK  = N / P;
   localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int COL_W   = (N > 1) ? $clog2(N) : 1;
   localparam int HIDX_W  = $clog2(N * M);
   localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NCHUNK - 1);
   localparam logic [7:0]         MAX_ITER_C = 8'(MAX_ITER);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DEC   = 3'd1,
      SYND  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t               state_reg, state_next;
   logic [N-1:0]         cw_reg, cw_next;
   logic [M-1:0]         acc_reg, acc_next;
   logic [CHUNK_W-1:0]   chunk_reg, chunk_next;
   logic [M-1:0]         syndrome_reg, syndrome_next;
   logic                 success_reg, success_next;
   logic [7:0]           iter_reg, iter_next;
   logic                 dec_start_reg, dec_start_next;

   // Per-lane contribution of one H_t column, gated by the latched codeword bit
   logic [M-1:0]         lane_term [P];
   logic [M-1:0]         chunk_xor;

   genvar gi;
   generate
      for (gi = 0; gi < P; gi++) begin : g_lane
         logic [COL_W-1:0]  col_idx;
         logic [HIDX_W-1:0] bit_base;
         assign col_idx       = COL_W'(int'(chunk_reg) * P + gi);
         assign bit_base      = HIDX_W'(int'(col_idx) * M);
         assign lane_term[gi] = cw_reg[col_idx] ? H_t[bit_base +: M] : '0;
      end
   endgenerate

   // Fold the P lane contributions of the current chunk into one vector
   always_comb begin
      chunk_xor = '0;
      for (int p = 0; p < P; p++) begin
         chunk_xor = chunk_xor ^ lane_term[p];
      end
   end

   // State register; reset parks the controller in IDLE and aborts any decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Datapath registers; everything clears on reset so outputs read as zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cw_reg        <= '0;
         acc_reg       <= '0;
         chunk_reg     <= '0;
         syndrome_reg  <= '0;
         success_reg   <= 1'b0;
         iter_reg      <= '0;
         dec_start_reg <= 1'b0;
      end else begin
         cw_reg        <= cw_next;
         acc_reg       <= acc_next;
         chunk_reg     <= chunk_next;
         syndrome_reg  <= syndrome_next;
         success_reg   <= success_next;
         iter_reg      <= iter_next;
         dec_start_reg <= dec_start_next;
      end
   end

   // Next-state and datapath update; dec_start is registered so it is high
   // exactly during the first cycle spent in DEC
   always_comb begin
      state_next     = state_reg;
      cw_next        = cw_reg;
      acc_next       = acc_reg;
      chunk_next     = chunk_reg;
      syndrome_next  = syndrome_reg;
      success_next   = success_reg;
      iter_next      = iter_reg;
      dec_start_next = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (start) begin
               iter_next      = 8'd1;
               success_next   = 1'b0;
               syndrome_next  = '0;
               dec_start_next = 1'b1;
               state_next     = DEC;
            end
         end

         DEC: begin
            // dec_done in the dec_start cycle is accepted like any other
            if (dec_done) begin
               cw_next    = cw;
               acc_next   = '0;
               chunk_next = '0;
               state_next = SYND;
            end
         end

         SYND: begin
            acc_next = acc_reg ^ chunk_xor;
            if (chunk_reg == LAST_CHUNK) begin
               syndrome_next = acc_reg ^ chunk_xor;
               state_next    = CHECK;
            end else begin
               chunk_next = chunk_reg + 1'b1;
            end
         end

         CHECK: begin
`ifdef LDPC_EARLY_TERM_EN
            if (syndrome_reg == '0) begin
               success_next = 1'b1;
               state_next   = DONE;
            end else if (iter_reg == MAX_ITER_C) begin
               success_next = 1'b0;
               state_next   = DONE;
            end else begin
               iter_next      = iter_reg + 8'd1;
               dec_start_next = 1'b1;
               state_next     = DEC;
            end
`else
            if (iter_reg == MAX_ITER_C) begin
               success_next = (syndrome_reg == '0);
               state_next   = DONE;
            end else begin
               iter_next      = iter_reg + 8'd1;
               dec_start_next = 1'b1;
               state_next     = DEC;
            end
`endif
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign dec_start = dec_start_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);
   assign success   = success_reg;
   assign iter_cnt  = iter_reg;
   assign syndrome  = syndrome_reg;

endmodule
